// File: rtl/e31_muldiv_pkg.sv
// Shared definitions for the E31 iterative RV32M multiply/divide unit:
// funct3 encodings, FSM state type and op-class helpers.
package e31_muldiv_pkg;

    localparam logic [2:0] FN_MUL    = 3'd0;
    localparam logic [2:0] FN_MULH   = 3'd1;
    localparam logic [2:0] FN_MULHSU = 3'd2;
    localparam logic [2:0] FN_MULHU  = 3'd3;
    localparam logic [2:0] FN_DIV    = 3'd4;
    localparam logic [2:0] FN_DIVU   = 3'd5;
    localparam logic [2:0] FN_REM    = 3'd6;
    localparam logic [2:0] FN_REMU   = 3'd7;

    localparam logic [5:0] LAST_STEP = 6'd31;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_PREP,
        ST_MUL,
        ST_DIV,
        ST_FIX,
        ST_DONE
    } state_t;

    function automatic logic is_div(input logic [2:0] fn);
        return fn[2];
    endfunction

    function automatic logic is_hi(input logic [2:0] fn);
        return (fn == FN_MULH) || (fn == FN_MULHSU) || (fn == FN_MULHU);
    endfunction

    function automatic logic is_rem(input logic [2:0] fn);
        return (fn == FN_REM) || (fn == FN_REMU);
    endfunction

    function automatic logic lhs_signed(input logic [2:0] fn);
        return (fn == FN_MULH) || (fn == FN_MULHSU) || (fn == FN_DIV) || (fn == FN_REM);
    endfunction

    function automatic logic rhs_signed(input logic [2:0] fn);
        return (fn == FN_MULH) || (fn == FN_DIV) || (fn == FN_REM);
    endfunction

endpackage

// File: rtl/e31_muldiv_iter.sv
// Iterative RV32M multiply/divide unit: radix-2 shift-add multiply and
// restoring divide sharing one add/sub, with valid/ready request and response.
module e31_muldiv_iter
    import e31_muldiv_pkg::*;
#(
    parameter int XLEN = 32,
    parameter int TAGW = 5
) (
    input  logic            clock,
    input  logic            reset,
    input  logic            io_req_valid,
    output logic            io_req_ready,
    input  logic [2:0]      io_req_bits_fn,
    input  logic [XLEN-1:0] io_req_bits_in1,
    input  logic [XLEN-1:0] io_req_bits_in2,
    input  logic [TAGW-1:0] io_req_bits_tag,
    input  logic            io_kill,
    output logic            io_resp_valid,
    input  logic            io_resp_ready,
    output logic [XLEN-1:0] io_resp_bits_data,
    output logic [TAGW-1:0] io_resp_bits_tag
);

    state_t          state_reg, state_next;
    logic [5:0]      cnt_reg, cnt_next;
    logic [2:0]      fn_reg, fn_next;
    logic [TAGW-1:0] tag_reg, tag_next;
    // mcand holds the sign-extended multiplicand (MUL) or the divisor (DIV).
    logic [32:0]     mcand_reg, mcand_next;
    // acc/lo form the {high, low} product, or {remainder, dividend/quotient}.
    logic [32:0]     acc_reg, acc_next;
    logic [31:0]     lo_reg, lo_next;
    logic            neg_q_reg, neg_q_next;
    logic            neg_r_reg, neg_r_next;
    logic [31:0]     resp_data_reg, resp_data_next;
    logic [TAGW-1:0] resp_tag_reg, resp_tag_next;

    logic [33:0]     add_x, add_y, add_sum;
    logic            add_sub;
    logic [32:0]     div_shift;

    assign add_sum   = add_sub ? (add_x - add_y) : (add_x + add_y);
    assign div_shift = {acc_reg[31:0], lo_reg[31]};

    always_ff @(posedge clock) begin
        if (reset) begin
            state_reg     <= ST_IDLE;
            cnt_reg       <= 6'd0;
            fn_reg        <= FN_MUL;
            tag_reg       <= '0;
            mcand_reg     <= 33'd0;
            acc_reg       <= 33'd0;
            lo_reg        <= 32'd0;
            neg_q_reg     <= 1'b0;
            neg_r_reg     <= 1'b0;
            resp_data_reg <= 32'd0;
            resp_tag_reg  <= '0;
        end else begin
            state_reg     <= state_next;
            cnt_reg       <= cnt_next;
            fn_reg        <= fn_next;
            tag_reg       <= tag_next;
            mcand_reg     <= mcand_next;
            acc_reg       <= acc_next;
            lo_reg        <= lo_next;
            neg_q_reg     <= neg_q_next;
            neg_r_reg     <= neg_r_next;
            resp_data_reg <= resp_data_next;
            resp_tag_reg  <= resp_tag_next;
        end
    end

    always_comb begin
        state_next     = state_reg;
        cnt_next       = cnt_reg;
        fn_next        = fn_reg;
        tag_next       = tag_reg;
        mcand_next     = mcand_reg;
        acc_next       = acc_reg;
        lo_next        = lo_reg;
        neg_q_next     = neg_q_reg;
        neg_r_next     = neg_r_reg;
        resp_data_next = resp_data_reg;
        resp_tag_next  = resp_tag_reg;
        add_x          = {acc_reg[32], acc_reg};
        add_y          = 34'd0;
        add_sub        = 1'b0;

        case (state_reg)
            ST_IDLE: begin
                if (io_req_valid) begin
                    fn_next    = io_req_bits_fn;
                    tag_next   = io_req_bits_tag;
                    acc_next   = 33'd0;
                    cnt_next   = 6'd0;
                    neg_q_next = 1'b0;
                    neg_r_next = 1'b0;
                    if (is_div(io_req_bits_fn)) begin
                        lo_next    = io_req_bits_in1;
                        mcand_next = {1'b0, io_req_bits_in2};
                        state_next = ST_PREP;
                    end else begin
                        lo_next    = io_req_bits_in2;
                        mcand_next = {lhs_signed(io_req_bits_fn) & io_req_bits_in1[31],
                                      io_req_bits_in1};
                        state_next = ST_MUL;
                    end
                end
            end
            ST_PREP: begin
                if (lhs_signed(fn_reg) && lo_reg[31])
                    lo_next = -lo_reg;
                if (rhs_signed(fn_reg) && mcand_reg[31])
                    mcand_next = {1'b0, -mcand_reg[31:0]};
                neg_q_next = lhs_signed(fn_reg) & (lo_reg[31] ^ mcand_reg[31]);
                neg_r_next = lhs_signed(fn_reg) & lo_reg[31];
                state_next = ST_DIV;
            end
            ST_MUL: begin
                // A signed multiplier's top bit carries weight -2^31, so the last step subtracts.
                add_x    = {acc_reg[32], acc_reg};
                add_y    = lo_reg[0] ? {mcand_reg[32], mcand_reg} : 34'd0;
                add_sub  = (cnt_reg == LAST_STEP) && rhs_signed(fn_reg);
                acc_next = add_sum[33:1];
                lo_next  = {add_sum[0], lo_reg[31:1]};
                cnt_next = cnt_reg + 6'd1;
                if (cnt_reg == LAST_STEP) begin
                    cnt_next   = 6'd0;
                    state_next = ST_DONE;
                end
            end
            ST_DIV: begin
                add_x    = {1'b0, div_shift};
                add_y    = {2'b00, mcand_reg[31:0]};
                add_sub  = 1'b1;
                acc_next = add_sum[33] ? {1'b0, div_shift[31:0]} : {1'b0, add_sum[31:0]};
                lo_next  = {lo_reg[30:0], ~add_sum[33]};
                cnt_next = cnt_reg + 6'd1;
                if (cnt_reg == LAST_STEP) begin
                    cnt_next   = 6'd0;
                    state_next = ST_FIX;
                end
            end
            ST_FIX: begin
                // Divide-by-zero keeps the all-ones quotient regardless of sign.
                if (neg_r_reg)
                    acc_next = {1'b0, -acc_reg[31:0]};
                if (neg_q_reg && (mcand_reg[31:0] != 32'd0))
                    lo_next = -lo_reg;
                state_next = ST_DONE;
            end
            ST_DONE: begin
                if (io_resp_ready)
                    state_next = ST_IDLE;
            end
            default: state_next = ST_IDLE;
        endcase

        if (io_kill && (state_reg != ST_IDLE)) begin
            state_next = ST_IDLE;
            cnt_next   = 6'd0;
        end

        if ((state_next == ST_DONE) && (state_reg != ST_DONE)) begin
            resp_data_next = (is_hi(fn_reg) || is_rem(fn_reg)) ? acc_next[31:0] : lo_next;
            resp_tag_next  = tag_reg;
        end
    end

    assign io_req_ready      = (state_reg == ST_IDLE);
    assign io_resp_valid     = (state_reg == ST_DONE);
    assign io_resp_bits_data = resp_data_reg;
    assign io_resp_bits_tag  = resp_tag_reg;

endmodule

// File: tb/tb_e31_muldiv_iter.sv
// Self-checking bench for e31_muldiv_iter: directed RV32M corner cases,
// randomized ops against an arithmetic reference, backpressure, kill and reset.
module tb_e31_muldiv_iter;

    logic        clock = 1'b0;
    logic        reset;
    logic        req_valid;
    logic        req_ready;
    logic [2:0]  req_fn;
    logic [31:0] req_in1;
    logic [31:0] req_in2;
    logic [4:0]  req_tag;
    logic        kill;
    logic        resp_valid;
    logic        resp_ready;
    logic [31:0] resp_data;
    logic [4:0]  resp_tag;

    int checks = 0;
    int errors = 0;

    always #5 clock = ~clock;

    e31_muldiv_iter #(.XLEN(32), .TAGW(5)) dut (
        .clock             (clock),
        .reset             (reset),
        .io_req_valid      (req_valid),
        .io_req_ready      (req_ready),
        .io_req_bits_fn    (req_fn),
        .io_req_bits_in1   (req_in1),
        .io_req_bits_in2   (req_in2),
        .io_req_bits_tag   (req_tag),
        .io_kill           (kill),
        .io_resp_valid     (resp_valid),
        .io_resp_ready     (resp_ready),
        .io_resp_bits_data (resp_data),
        .io_resp_bits_tag  (resp_tag)
    );

    // Reference: RISC-V M-extension results from plain integer arithmetic.
    function automatic logic [31:0] ref_model(input logic [2:0] fn, input logic [31:0] a,
                                              input logic [31:0] b);
        int          sa;
        int          sb;
        longint      sp;
        logic [63:0] up;
        logic [31:0] r;
        sa = a;
        sb = b;
        r  = 32'd0;
        case (fn)
            3'd0: begin up = {32'd0, a} * {32'd0, b}; r = up[31:0]; end
            3'd1: begin sp = longint'(sa) * longint'(sb); up = sp; r = up[63:32]; end
            3'd2: begin sp = longint'(sa) * longint'({32'd0, b}); up = sp; r = up[63:32]; end
            3'd3: begin up = {32'd0, a} * {32'd0, b}; r = up[63:32]; end
            3'd4: begin
                if (b == 32'd0) r = 32'hFFFF_FFFF;
                else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) r = 32'h8000_0000;
                else r = sa / sb;
            end
            3'd5: r = (b == 32'd0) ? 32'hFFFF_FFFF : a / b;
            3'd6: begin
                if (b == 32'd0) r = a;
                else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) r = 32'd0;
                else r = sa % sb;
            end
            default: r = (b == 32'd0) ? a : a % b;
        endcase
        return r;
    endfunction

    // Issues one op, waits for its response (bounded) and checks latency, data, tag, handshake.
    task automatic run_op(input logic [2:0] fn, input logic [31:0] a, input logic [31:0] b,
                          input logic [4:0] tag, input logic kill_at_fire);
        logic [31:0] exp;
        int          lat;
        int          n;
        logic        busy_ok;
        exp     = ref_model(fn, a, b);
        lat     = fn[2] ? 35 : 33;
        busy_ok = 1'b1;
        checks++;
        if (req_ready !== 1'b1) begin
            errors++;
            $display("FAIL req_ready_before_issue got %b want 1", req_ready);
        end
        req_valid  = 1'b1;
        req_fn     = fn;
        req_in1    = a;
        req_in2    = b;
        req_tag    = tag;
        kill       = kill_at_fire;
        resp_ready = 1'b1;
        @(posedge clock); #1;
        req_valid = 1'b0;
        kill      = 1'b0;
        req_in1   = $urandom;
        req_in2   = $urandom;
        n = 1;
        while (resp_valid !== 1'b1 && n < 100) begin
            if (req_ready !== 1'b0) busy_ok = 1'b0;
            @(posedge clock); #1;
            n++;
        end
        checks++;
        if (n != lat) begin
            errors++;
            $display("FAIL latency fn=%0d got %0d want %0d", fn, n, lat);
        end
        checks++;
        if (!busy_ok) begin
            errors++;
            $display("FAIL req_ready_busy fn=%0d got 1 while busy want 0", fn);
        end
        checks++;
        if (resp_data !== exp) begin
            errors++;
            $display("FAIL data fn=%0d a=%h b=%h got %h want %h", fn, a, b, resp_data, exp);
        end
        checks++;
        if (resp_tag !== tag) begin
            errors++;
            $display("FAIL tag fn=%0d got %0d want %0d", fn, resp_tag, tag);
        end
        $display("op fn=%0d a=%h b=%h tag=%0d -> data=%h tag=%0d lat=%0d (exp %h)",
                 fn, a, b, tag, resp_data, resp_tag, n, exp);
        @(posedge clock); #1;
        checks++;
        if (req_ready !== 1'b1 || resp_valid !== 1'b0) begin
            errors++;
            $display("FAIL after_resp_fire got ready=%b valid=%b want ready=1 valid=0",
                     req_ready, resp_valid);
        end
    endtask

    task automatic test_reset();
        checks++;
        if (req_ready !== 1'b1 || resp_valid !== 1'b0 || resp_data !== 32'd0 || resp_tag !== 5'd0) begin
            errors++;
            $display("FAIL reset_state got ready=%b valid=%b data=%h tag=%0d want 1 0 0 0",
                     req_ready, resp_valid, resp_data, resp_tag);
        end
    endtask

    task automatic test_directed();
        run_op(3'd0, 32'd7, 32'd6, 5'd17, 1'b0);
        run_op(3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd1, 1'b0);
        run_op(3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd2, 1'b0);
        run_op(3'd2, 32'hFFFF_FFFF, 32'd2, 5'd3, 1'b0);
        run_op(3'd4, 32'hFFFF_FFF9, 32'd2, 5'd4, 1'b0);
        run_op(3'd6, 32'hFFFF_FFF9, 32'd2, 5'd5, 1'b0);
        run_op(3'd5, 32'd100, 32'd7, 5'd6, 1'b0);
        run_op(3'd7, 32'd100, 32'd7, 5'd7, 1'b0);
        run_op(3'd4, 32'hFFFF_FFF9, 32'd0, 5'd8, 1'b0);
        run_op(3'd6, 32'd123, 32'd0, 5'd9, 1'b0);
        run_op(3'd6, 32'hFFFF_FF85, 32'd0, 5'd10, 1'b0);
        run_op(3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 5'd11, 1'b0);
        run_op(3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 5'd12, 1'b0);
        run_op(3'd1, 32'h8000_0000, 32'h8000_0000, 5'd13, 1'b0);
        run_op(3'd2, 32'h8000_0000, 32'hFFFF_FFFF, 5'd14, 1'b0);
    endtask

    function automatic logic [31:0] pick_operand();
        case ($urandom_range(0, 5))
            0: return 32'd0;
            1: return 32'hFFFF_FFFF;
            2: return 32'h8000_0000;
            3: return 32'($urandom_range(0, 20));
            default: return $urandom;
        endcase
    endfunction

    task automatic test_random();
        for (int i = 0; i < 40; i++) begin
            logic [2:0]  fn;
            logic [31:0] a;
            logic [31:0] b;
            fn = 3'($urandom_range(0, 7));
            a  = pick_operand();
            b  = pick_operand();
            run_op(fn, a, b, 5'($urandom_range(0, 31)), 1'b0);
        end
    endtask

    task automatic test_kill_with_fire();
        run_op(3'd0, 32'd12, 32'd12, 5'd21, 1'b1);
    endtask

    task automatic test_backpressure();
        logic [31:0] exp;
        int          n;
        logic        stable;
        exp = ref_model(3'd5, 32'd1000, 32'd33);
        req_valid = 1'b1; req_fn = 3'd5; req_in1 = 32'd1000; req_in2 = 32'd33; req_tag = 5'd22;
        resp_ready = 1'b0;
        @(posedge clock); #1;
        req_valid = 1'b0;
        n = 1;
        while (resp_valid !== 1'b1 && n < 100) begin @(posedge clock); #1; n++; end
        checks++;
        if (n != 35 || resp_data !== exp || resp_tag !== 5'd22) begin
            errors++;
            $display("FAIL bp_result got lat=%0d data=%h tag=%0d want 35 %h 22", n, resp_data, resp_tag, exp);
        end
        stable = 1'b1;
        for (int c = 0; c < 10; c++) begin
            @(posedge clock); #1;
            if (resp_valid !== 1'b1 || req_ready !== 1'b0 || resp_data !== exp || resp_tag !== 5'd22)
                stable = 1'b0;
        end
        checks++;
        if (!stable) begin
            errors++;
            $display("FAIL bp_hold got unstable outputs want data=%h tag=22 held", exp);
        end
        $display("op backpressure DIVU 1000/33 held 10 cycles data=%h tag=%0d", resp_data, resp_tag);
        resp_ready = 1'b1;
        @(posedge clock); #1;
        checks++;
        if (req_ready !== 1'b1 || resp_valid !== 1'b0) begin
            errors++;
            $display("FAIL bp_release got ready=%b valid=%b want 1 0", req_ready, resp_valid);
        end
    endtask

    task automatic test_kill();
        logic seen;
        req_valid = 1'b1; req_fn = 3'd0; req_in1 = 32'd5; req_in2 = 32'd9; req_tag = 5'd23;
        resp_ready = 1'b1;
        @(posedge clock); #1;
        req_valid = 1'b0;
        repeat (10) @(posedge clock);
        #1;
        kill = 1'b1;
        @(posedge clock); #1;
        kill = 1'b0;
        checks++;
        if (req_ready !== 1'b1 || resp_valid !== 1'b0) begin
            errors++;
            $display("FAIL kill_mul got ready=%b valid=%b want 1 0", req_ready, resp_valid);
        end
        seen = 1'b0;
        for (int c = 0; c < 40; c++) begin
            @(posedge clock); #1;
            if (resp_valid === 1'b1) seen = 1'b1;
        end
        checks++;
        if (seen) begin
            errors++;
            $display("FAIL kill_mul_no_resp got resp_valid=1 want 0");
        end
        $display("op kill MUL at count 10 ready=%b", req_ready);
        // Kill while a response waits in DONE drops it.
        req_valid = 1'b1; req_fn = 3'd7; req_in1 = 32'd50; req_in2 = 32'd8; req_tag = 5'd24;
        resp_ready = 1'b0;
        @(posedge clock); #1;
        req_valid = 1'b0;
        for (int c = 0; c < 100 && resp_valid !== 1'b1; c++) begin @(posedge clock); #1; end
        kill = 1'b1;
        @(posedge clock); #1;
        kill = 1'b0;
        resp_ready = 1'b1;
        checks++;
        if (req_ready !== 1'b1 || resp_valid !== 1'b0) begin
            errors++;
            $display("FAIL kill_done got ready=%b valid=%b want 1 0", req_ready, resp_valid);
        end
        $display("op kill in DONE ready=%b valid=%b", req_ready, resp_valid);
    endtask

    task automatic test_reset_mid_div();
        req_valid = 1'b1; req_fn = 3'd4; req_in1 = 32'd999; req_in2 = 32'd3; req_tag = 5'd25;
        resp_ready = 1'b1;
        @(posedge clock); #1;
        req_valid = 1'b0;
        repeat (10) @(posedge clock);
        #1;
        reset = 1'b1;
        @(posedge clock); #1;
        reset = 1'b0;
        checks++;
        if (req_ready !== 1'b1 || resp_valid !== 1'b0 || resp_data !== 32'd0 || resp_tag !== 5'd0) begin
            errors++;
            $display("FAIL reset_mid_div got ready=%b valid=%b data=%h tag=%0d want 1 0 0 0",
                     req_ready, resp_valid, resp_data, resp_tag);
        end
        $display("op reset mid-DIV ready=%b data=%h", req_ready, resp_data);
        run_op(3'd0, 32'd3, 32'd3, 5'd26, 1'b0);
    endtask

    initial begin
        reset      = 1'b1;
        req_valid  = 1'b0;
        req_fn     = 3'd0;
        req_in1    = 32'd0;
        req_in2    = 32'd0;
        req_tag    = 5'd0;
        kill       = 1'b0;
        resp_ready = 1'b1;
        repeat (3) @(posedge clock);
        #1;
        reset = 1'b0;
        test_reset();
        test_directed();
        test_random();
        test_kill_with_fire();
        test_backpressure();
        test_kill();
        test_reset_mid_div();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/e31_muldiv_iter.md
# e31_muldiv_iter

Iterative RV32M multiply/divide unit sitting beside the single-cycle integer ALU in the E31 execute stage. The ALU resolves every integer op combinationally. This block takes the ops the ALU cannot: MUL/MULH/MULHSU/MULHU/DIV/DIVU/REM/REMU. It accepts one request through a valid/ready handshake and returns one tagged result through a valid/ready handshake. It uses a radix-2 shift-add / restoring-divide datapath with fixed, op-class-dependent latency.

## Interface

Parameters:
- XLEN, 32, operand/result width. Only 32 is supported.
- TAGW, 5, destination-register tag width.

Ports:
- clock  in  1  sole clock
- reset  in  1  synchronous, active-high
- io_req_valid  in  1  request present
- io_req_ready  out  1  unit idle, can accept
- io_req_bits_fn  in  3  RV32M funct3: 0 MUL, 1 MULH, 2 MULHSU, 3 MULHU, 4 DIV, 5 DIVU, 6 REM, 7 REMU
- io_req_bits_in1  in  32  rs1 (multiplicand / dividend)
- io_req_bits_in2  in  32  rs2 (multiplier / divisor)
- io_req_bits_tag  in  TAGW  returned unchanged with the response
- io_kill  in  1  abort in-flight op (pipeline flush)
- io_resp_valid  out  1  result available
- io_resp_ready  in  1  consumer accepts result
- io_resp_bits_data  out  32  result
- io_resp_bits_tag  out  TAGW  tag of the op

## Operation

States: IDLE, PREP, MUL, DIV, FIX, DONE.
- IDLE: req_ready=1. On req fire, capture fn, tag and operands.
  - Multiply ops (fn<4) go to MUL.
  - Divide ops go to PREP.
- PREP (1 cycle): replace signed operands with their magnitudes (DIV/REM on both operands). Record neg_q = sign(in1)^sign(in2) and neg_r = sign(in1). Both are 0 for DIVU/REMU. Go to DIV.
- MUL (32 cycles, 6-bit counter 0..31): 64-bit product register, one add-and-shift per cycle. Signedness per operand: MULH signed×signed, MULHSU signed×unsigned, MULHU and MUL unsigned.
  - The signed product is formed by sign-extending to 33 bits.
  - The top step is subtracted rather than added when the multiplier is signed.
  - After count 31, go to DONE.
- DIV (32 cycles): restoring division with a 33-bit subtractor.
  - Remainder shifts left one bit per cycle, taking the next dividend bit.
  - Quotient bit = no borrow.
  - After count 31, go to FIX.
- FIX (1 cycle): negate the quotient when neg_q, except when the divisor is zero. Negate the remainder when neg_r. Go to DONE.
- DONE: resp_valid=1 and data held stable. On resp fire, go to IDLE.

Result selection:
- MUL: product[31:0]
- MULH/MULHSU/MULHU: product[63:32]
- DIV/DIVU: quotient
- REM/REMU: remainder

Required corner results (RISC-V spec), all produced by the datapath without special cases except the FIX suppression above:
- Divide by zero: quotient 0xFFFFFFFF, remainder = in1.
- DIV 0x80000000 / 0xFFFFFFFF: 0x80000000, REM 0.

Kill and reset:
- io_kill in any state other than IDLE: next state is IDLE with no response. This includes DONE, where the response is dropped.
- io_kill in IDLE: ignored.
- An io_kill coinciding with a req fire in IDLE does not cancel that request.
- reset has priority over everything.

## Timing

- Reset values: req_ready=1, resp_valid=0, resp_bits_data=0, resp_bits_tag=0, state IDLE, counter 0.
- Latency from req fire (cycle T) to first resp_valid:
  - Multiply: T+33.
  - Divide: T+35.
- req_ready is 0 from T+1 until the cycle after resp fire. There is no back-to-back issue; minimum initiation interval is latency+1.
- Once resp_valid rises, data and tag must not change until resp fire, kill or reset.
- No combinational path from io_req_* to io_resp_*. io_req_ready depends on state only.

## Structure

- Package e31_muldiv_pkg:
  - fn encoding localparams (FN_MUL..FN_REMU)
  - state enum
  - helpers is_div(fn), is_hi(fn), lhs_signed(fn), rhs_signed(fn)
- Single flat module. The shared 33-bit add/sub is used by both MUL and DIV, so no sub-module is needed.

## Test plan

- MUL 7×6: resp_valid first at T+33, data 42, tag echoed.
- MULH 0xFFFFFFFF×0xFFFFFFFF → 0. MULHU same operands → 0xFFFFFFFE. MULHSU 0xFFFFFFFF×2 → 0xFFFFFFFF.
- DIV −7/2 → 0xFFFFFFFD (−3). REM −7/2 → 0xFFFFFFFF (−1). DIVU 100/7 → 14. REMU 100/7 → 2. resp_valid first at T+35.
- DIV x/0 → 0xFFFFFFFF. REM 123/0 → 123. DIV 0x80000000/0xFFFFFFFF → 0x80000000. REM of the same → 0.
- Hold io_resp_ready=0 for 10 cycles after DONE: data and tag stable, req_ready=0. Then accept, and req_ready returns to 1 next cycle.
- io_kill at MUL count 10: no response ever appears and req_ready=1 next cycle. reset asserted mid-DIV: outputs return to reset values next cycle. A fresh MUL 3×3 then returns 9.
